// File: rtl/lc3_ctrl_seq_pkg.sv
// Shared types, state codes and the control ROM for the LC-3 multi-cycle sequencer.
// State codes follow the classic LC-3 numbering so the debug STATE port matches textbook traces.
package lc3_ctrl_seq_pkg;

  typedef logic [5:0] state_t;

  localparam state_t S_BR1   = 6'd0,  S_ADD   = 6'd1,  S_LD    = 6'd2,  S_ST    = 6'd3;
  localparam state_t S_JSR   = 6'd4,  S_AND   = 6'd5,  S_LDR   = 6'd6,  S_STR   = 6'd7;
  localparam state_t S_NOT   = 6'd9,  S_LDI   = 6'd10, S_STI   = 6'd11, S_JMP   = 6'd12;
  localparam state_t S_LEA   = 6'd14, S_TRAP  = 6'd15, S_MEM22 = 6'd16, S_FETCH1 = 6'd18;
  localparam state_t S_JSR0  = 6'd20, S_JSR1  = 6'd21, S_BR2   = 6'd22, S_MEM21 = 6'd23;
  localparam state_t S_LDI2  = 6'd24, S_MEM11 = 6'd25, S_LDI3  = 6'd26, S_LD3   = 6'd27;
  localparam state_t S_TRAP2 = 6'd28, S_STI2  = 6'd29, S_TRAP3 = 6'd30, S_STI3  = 6'd31;
  localparam state_t S_DECODE = 6'd32, S_FETCH2 = 6'd33, S_FETCH3 = 6'd35;
  localparam state_t S_INT1  = 6'd40, S_INT2  = 6'd41, S_INT3  = 6'd42, S_ILL   = 6'd43;

  localparam logic [3:0] OP_RTI = 4'b1000, OP_RES = 4'b1101;

  localparam logic [1:0] PCMUX_INC = 2'b00, PCMUX_BUS = 2'b01, PCMUX_ADD = 2'b10;
  localparam logic [1:0] DRMUX_IR = 2'b00, DRMUX_R7 = 2'b01;
  localparam logic [1:0] SR1MUX_IR11 = 2'b00, SR1MUX_IR8 = 2'b01;
  localparam logic [1:0] ADDR2_ZERO = 2'b00, ADDR2_OFF6 = 2'b01, ADDR2_OFF9 = 2'b10, ADDR2_OFF11 = 2'b11;
  localparam logic       ADDR1_PC = 1'b0, ADDR1_BASER = 1'b1;
  localparam logic       MARMUX_ZEXT = 1'b0, MARMUX_ADDER = 1'b1;
  localparam logic [1:0] ALUK_ADD = 2'b00, ALUK_AND = 2'b01, ALUK_NOT = 2'b10, ALUK_PASSA = 2'b11;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_reg;
    logic       ld_cc;
    logic       ld_pc;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic       gate_vec;
    logic [1:0] pcmux;
    logic [1:0] drmux;
    logic [1:0] sr1mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic       marmux;
    logic [1:0] aluk;
    logic       cs;
    logic       we;
  } lc3_ctrl_t;

  localparam int CTRL_W = $bits(lc3_ctrl_t);

  function automatic lc3_ctrl_t ctrl_rom(input state_t s);
    lc3_ctrl_t c;
    c = '0;
    case (s)
      S_FETCH1: begin c.ld_mar = 1'b1; c.gate_pc = 1'b1; c.ld_pc = 1'b1; c.pcmux = PCMUX_INC; end
      S_FETCH2, S_MEM11, S_LDI2, S_STI2, S_INT3: begin c.cs = 1'b1; c.ld_mdr = 1'b1; end
      S_FETCH3: begin c.gate_mdr = 1'b1; c.ld_ir = 1'b1; end
      S_DECODE: c.ld_ben = 1'b1;
      S_BR2: begin
        c.ld_pc = 1'b1; c.pcmux = PCMUX_ADD; c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9;
      end
      S_ADD, S_AND, S_NOT: begin
        c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.gate_alu = 1'b1; c.sr1mux = SR1MUX_IR8; c.drmux = DRMUX_IR;
        c.aluk = (s == S_ADD) ? ALUK_ADD : (s == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_LEA: begin
        c.ld_reg = 1'b1; c.gate_marmux = 1'b1; c.marmux = MARMUX_ADDER;
        c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9;
      end
      S_JMP, S_JSR0: begin
        c.ld_pc = 1'b1; c.pcmux = PCMUX_ADD; c.addr1mux = ADDR1_BASER;
        c.addr2mux = ADDR2_ZERO; c.sr1mux = SR1MUX_IR8;
      end
      S_JSR1: begin
        c.ld_pc = 1'b1; c.pcmux = PCMUX_ADD; c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF11;
      end
      S_LD, S_LDI, S_ST, S_STI: begin
        c.ld_mar = 1'b1; c.gate_marmux = 1'b1; c.marmux = MARMUX_ADDER;
        c.addr1mux = ADDR1_PC; c.addr2mux = ADDR2_OFF9;
      end
      S_LDR, S_STR: begin
        c.ld_mar = 1'b1; c.gate_marmux = 1'b1; c.marmux = MARMUX_ADDER;
        c.addr1mux = ADDR1_BASER; c.addr2mux = ADDR2_OFF6; c.sr1mux = SR1MUX_IR8;
      end
      S_LDI3, S_STI3: begin c.ld_mar = 1'b1; c.gate_mdr = 1'b1; end
      S_LD3: begin c.ld_reg = 1'b1; c.ld_cc = 1'b1; c.gate_mdr = 1'b1; c.drmux = DRMUX_IR; end
      S_MEM21: begin c.ld_mdr = 1'b1; c.gate_alu = 1'b1; c.aluk = ALUK_PASSA; c.sr1mux = SR1MUX_IR11; end
      S_MEM22: begin c.cs = 1'b1; c.we = 1'b1; end
      S_JSR, S_INT2: begin c.ld_reg = 1'b1; c.gate_pc = 1'b1; c.drmux = DRMUX_R7; end
      S_TRAP: begin c.ld_mar = 1'b1; c.gate_marmux = 1'b1; c.marmux = MARMUX_ZEXT; end
      // Vector fetch and return-link save share the one memory wait.
      S_TRAP2: begin
        c.cs = 1'b1; c.ld_mdr = 1'b1; c.ld_reg = 1'b1; c.gate_pc = 1'b1; c.drmux = DRMUX_R7;
      end
      S_TRAP3: begin c.ld_pc = 1'b1; c.pcmux = PCMUX_BUS; c.gate_mdr = 1'b1; end
      S_INT1, S_ILL: begin c.ld_mar = 1'b1; c.gate_vec = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lc3_ctrl_seq_mem_wait.sv
// READY wait tracker for memory states: counts stalled cycles and flags a timeout.
// READY in the same cycle as the limit wins, so timeout is qualified by !ready.
module lc3_ctrl_seq_mem_wait #(
  parameter int MEM_TMO = 255
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic ready,
  output logic done,
  output logic timeout
);

  localparam int CW = (MEM_TMO < 1) ? 1 : $clog2(MEM_TMO + 1);
  localparam int LIM = (MEM_TMO < 1) ? 0 : MEM_TMO - 1;
  localparam logic [CW-1:0] LIM_C = CW'(LIM);

  logic [CW-1:0] cnt;

  assign done    = en & ready;
  assign timeout = (MEM_TMO != 0) && en && !ready && (cnt == LIM_C);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      cnt <= '0;
    else if (en && !ready && !timeout)
      cnt <= cnt + 1'b1;
    else
      cnt <= '0;
  end

endmodule

// File: rtl/lc3_ctrl_seq.sv
// LC-3 multi-cycle control sequencer: Moore FSM with READY timeout, interrupt entry and illegal-op trap.
// Controls are a ROM lookup of the registered state; only RESET gates them directly.
module lc3_ctrl_seq
  import lc3_ctrl_seq_pkg::*;
#(
  parameter int         MEM_TMO = 255,
  parameter bit         INT_EN  = 1'b1,
  parameter logic [7:0] INT_VEC = 8'h80,
  parameter logic [7:0] ILL_VEC = 8'h01
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READY,
  input  logic [15:0]       IR,
  input  logic              N,
  input  logic              Z,
  input  logic              P,
  input  logic              INT_REQ,
  output logic [CTRL_W-1:0] CTRL,
  output logic [7:0]        VECTOR,
  output logic              INT_ACK,
  output logic [1:0]        FAULT,
  output logic [5:0]        STATE
);

  state_t    state, nxt;
  logic      ben;
  logic [1:0] fault;
  lc3_ctrl_t cur;
  logic      mem_done, tmo;
  logic      unused_ir;

  assign cur       = ctrl_rom(state);
  assign unused_ir = ^IR[8:0];

  lc3_ctrl_seq_mem_wait #(.MEM_TMO(MEM_TMO)) u_wait (
    .CLK    (CLK),
    .RESET  (RESET),
    .en     (cur.cs),
    .ready  (READY),
    .done   (mem_done),
    .timeout(tmo)
  );

  always_comb begin
    nxt = S_FETCH1;
    case (state)
      S_FETCH1: nxt = (INT_EN && INT_REQ) ? S_INT1 : S_FETCH2;
      S_FETCH2: nxt = S_FETCH3;
      S_FETCH3: nxt = S_DECODE;
      // Dispatch state numbers equal the opcode, except the two reserved encodings.
      S_DECODE: nxt = (IR[15:12] == OP_RTI || IR[15:12] == OP_RES) ? S_ILL : {2'b00, IR[15:12]};
      S_BR1:    nxt = ben ? S_BR2 : S_FETCH1;
      S_LD, S_LDR:  nxt = S_MEM11;
      S_LDI:    nxt = S_LDI2;
      S_LDI2:   nxt = S_LDI3;
      S_LDI3:   nxt = S_MEM11;
      S_MEM11:  nxt = S_LD3;
      S_ST, S_STR:  nxt = S_MEM21;
      S_STI:    nxt = S_STI2;
      S_STI2:   nxt = S_STI3;
      S_STI3:   nxt = S_MEM21;
      S_MEM21:  nxt = S_MEM22;
      S_JSR:    nxt = IR[11] ? S_JSR1 : S_JSR0;
      S_TRAP:   nxt = S_TRAP2;
      S_TRAP2:  nxt = S_TRAP3;
      S_INT1, S_ILL: nxt = S_INT2;
      S_INT2:   nxt = S_INT3;
      S_INT3:   nxt = S_TRAP3;
      default:  nxt = S_FETCH1;
    endcase
    if (cur.cs && !mem_done)
      nxt = tmo ? S_ILL : state;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_FETCH1;
      ben   <= 1'b0;
      fault <= 2'b00;
    end else begin
      state <= nxt;
      if (state == S_DECODE)
        ben <= (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
      if (tmo)
        fault <= 2'b10;
      else if (state == S_ILL && fault != 2'b10)
        fault <= 2'b01;
      else if (state == S_FETCH1)
        fault <= 2'b00;
    end
  end

  assign CTRL    = RESET ? '0 : cur;
  assign VECTOR  = cur.gate_vec ? ((state == S_INT1) ? INT_VEC : ILL_VEC) : 8'h00;
  assign INT_ACK = (state == S_INT1);
  assign FAULT   = fault;
  assign STATE   = state;

endmodule
